// File: rtl/simon_enc_core.sv
// rtl/simon_enc_core.sv - iterative SIMON 64/128 and 128/128 block datapath, one round per clock
// Optional decrypt path (i_dir port, reversed key order, half swaps) enabled by `define SIMON_DEC_EN
module simon_enc_core #(
  parameter int SIMON_MAX_ROUNDS     = 68,
  parameter int SIMON_MAX_WORD_WIDTH = 64
) (
  input  logic                            i_ck,
  input  logic                            i_nrst,
  input  logic                            i_mode,
`ifdef SIMON_DEC_EN
  input  logic                            i_dir,
`endif
  input  logic                            i_kexp_valid,
  output logic [6:0]                      o_rk_addr,
  input  logic [SIMON_MAX_WORD_WIDTH-1:0] i_rk_word,
  input  logic [127:0]                    i_din,
  input  logic                            i_din_valid,
  output logic                            o_din_ready,
  output logic [127:0]                    o_dout,
  output logic                            o_dout_valid,
  input  logic                            i_dout_ready,
  output logic                            o_busy
);

  // Last round index per mode: 44 rounds for 64/128, full key array depth for 128/128
  localparam logic [6:0] LAST_64  = 7'd43;
  localparam logic [6:0] LAST_128 = 7'(SIMON_MAX_ROUNDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [63:0] r_x;
  logic [63:0] r_y;
  logic [6:0]  r_rc;
  logic        r_mode;

  logic [6:0]  w_last_idx;
  logic        w_last_round;
  logic        w_accept;
  logic [6:0]  w_rk_idx;
  logic [63:0] w_din_x;
  logic [63:0] w_din_y;
  logic [63:0] w_load_x;
  logic [63:0] w_load_y;
  logic [63:0] w_x_nxt;
  logic [63:0] w_done_x;
  logic [63:0] w_done_y;

  // SIMON round function at 32-bit word width
  function automatic logic [31:0] simon_f32(input logic [31:0] v);
    return ({v[30:0], v[31]} & {v[23:0], v[31:24]}) ^ {v[29:0], v[31:30]};
  endfunction

  // SIMON round function at 64-bit word width
  function automatic logic [63:0] simon_f64(input logic [63:0] v);
    return ({v[62:0], v[63]} & {v[55:0], v[63:56]}) ^ {v[61:0], v[63:62]};
  endfunction

  assign w_last_idx   = r_mode ? LAST_128 : LAST_64;
  assign w_last_round = (r_rc == w_last_idx);
  assign w_accept     = (r_state == S_IDLE) && i_kexp_valid && i_din_valid;

  // Block unpacking; the 64/128 upper halves are held at zero from the load onward
  assign w_din_x = i_mode ? i_din[127:64] : {32'b0, i_din[63:32]};
  assign w_din_y = i_mode ? i_din[63:0]   : {32'b0, i_din[31:0]};

  // One round on the current state; the key word is truncated to the active width
  assign w_x_nxt = r_mode ? (r_y ^ simon_f64(r_x) ^ i_rk_word[63:0])
                          : {32'b0, r_y[31:0] ^ simon_f32(r_x[31:0]) ^ i_rk_word[31:0]};

`ifdef SIMON_DEC_EN
  logic r_dir;

  // Decryption reuses the encrypt round: swap halves in, walk keys backwards, swap halves out
  assign w_load_x = i_dir ? w_din_y : w_din_x;
  assign w_load_y = i_dir ? w_din_x : w_din_y;
  assign w_rk_idx = r_dir ? (w_last_idx - r_rc) : r_rc;
  assign w_done_x = r_dir ? r_x : w_x_nxt;
  assign w_done_y = r_dir ? w_x_nxt : r_x;

  // Direction is captured with the block so it stays fixed for the whole transaction
  always_ff @(posedge i_ck) begin
    if (!i_nrst) begin
      r_dir <= 1'b0;
    end else if (w_accept) begin
      r_dir <= i_dir;
    end
  end
`else
  assign w_load_x = w_din_x;
  assign w_load_y = w_din_y;
  assign w_rk_idx = r_rc;
  assign w_done_x = w_x_nxt;
  assign w_done_y = r_x;
`endif

  // State register
  always_ff @(posedge i_ck) begin
    if (!i_nrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)     w_state_nxt = S_RUN;
      S_RUN:   if (w_last_round) w_state_nxt = S_DONE;
      S_DONE:  if (i_dout_ready) w_state_nxt = S_IDLE;
      default:                   w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state register
  always_comb begin
    o_din_ready  = (r_state == S_IDLE) && i_kexp_valid;
    o_dout_valid = (r_state == S_DONE);
    o_busy       = (r_state == S_RUN);
    o_rk_addr    = (r_state == S_RUN) ? w_rk_idx : 7'd0;
  end

  // Datapath: load on acceptance, one round per RUN cycle, hold through DONE
  always_ff @(posedge i_ck) begin
    if (!i_nrst) begin
      r_x    <= 64'd0;
      r_y    <= 64'd0;
      r_rc   <= 7'd0;
      r_mode <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mode <= i_mode;
            r_x    <= w_load_x;
            r_y    <= w_load_y;
            r_rc   <= 7'd0;
          end
        end
        S_RUN: begin
          if (w_last_round) begin
            r_x <= w_done_x;
            r_y <= w_done_y;
          end else begin
            r_x  <= w_x_nxt;
            r_y  <= r_x;
            r_rc <= r_rc + 7'd1;
          end
        end
        S_DONE: begin
          if (i_dout_ready) begin
            r_rc <= 7'd0;
          end
        end
        default: begin
          r_rc <= 7'd0;
        end
      endcase
    end
  end

  // Result packing mirrors the input packing; upper 64 bits are zero in 64/128 mode
  assign o_dout = r_mode ? {r_x, r_y} : {64'd0, r_x[31:0], r_y[31:0]};

endmodule
